// File: rtl/host_reg_file.sv
// rtl/host_reg_file.sv - CPU host register file: config bank, sticky status, RMON indirect read.
// Optional config write lock enabled by defining REG_WR_LOCK_EN.
module host_reg_file #(
  parameter int                 DW      = 16,
  parameter int                 AW      = 8,
  parameter int                 NREG    = 35,
  parameter logic [NREG*DW-1:0] RST_VAL = '0,
  parameter logic [NREG*DW-1:0] SC_MASK = '0,
  parameter int                 NSTAT   = 8,
  parameter int                 RMON_AW = 6,
  parameter int                 TIMEOUT = 255
) (
  input  logic                 Clk_reg,
  input  logic                 Reset,
  input  logic                 CSB,
  input  logic                 WRB,
  input  logic [AW-1:0]        CA,
  input  logic [DW-1:0]        CD_in,
  output logic [DW-1:0]        CD_out,
  output logic [NREG*DW-1:0]   cfg_out,
  output logic [NREG-1:0]      cfg_wr,
  input  logic [NSTAT-1:0]     stat_set,
  output logic [RMON_AW-1:0]   CPU_rd_addr,
  output logic                 CPU_rd_apply,
  input  logic                 CPU_rd_grant,
  input  logic [31:0]          CPU_rd_dout
);

  localparam int WW = AW - 1;
  typedef logic [WW-1:0] widx_t;

  localparam widx_t A_STAT = widx_t'(NREG);
  localparam widx_t A_CMD  = widx_t'(NREG + 1);
  localparam widx_t A_LO   = widx_t'(NREG + 2);
  localparam widx_t A_HI   = widx_t'(NREG + 3);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  widx_t            widx;
  logic             acc;
  logic             acc_d;
  logic             wr_stb;
  logic             rd_stb;
  logic             cfg_we;
  logic             cmd_wr;
  logic [DW-1:0]    cfg [NREG];
  logic [DW-1:0]    rd_data;
  logic [DW-1:0]    cmd_word;
  logic [NSTAT-1:0] sticky;
  logic [31:0]      dout_q;
  logic [15:0]      tcnt;
  logic             done;
  logic             err;
  logic             busy;
  state_t           state;
  logic             unused_bits;

  assign widx        = CA[AW-1:1];
  assign acc         = !CSB;
  assign wr_stb      = acc & !WRB & !acc_d;
  assign rd_stb      = acc & WRB & !acc_d;
  assign cmd_wr      = wr_stb && (widx == A_CMD);
  assign unused_bits = CA[0];

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) acc_d <= 1'b0;
    else       acc_d <= acc;
  end

`ifdef REG_WR_LOCK_EN
  localparam widx_t A_LOCK = widx_t'(NREG + 4);
  logic locked;

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset)
      locked <= 1'b1;
    else if (wr_stb && (widx == A_LOCK))
      locked <= (CD_in[15:0] != 16'hA5C3);
  end

  assign cfg_we = wr_stb & !locked;
`else
  assign cfg_we = wr_stb;
`endif

  // Self-clearing bits survive exactly one cycle after the write that set them.
  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++)
        cfg[i] <= RST_VAL[i*DW +: DW] & ~SC_MASK[i*DW +: DW];
      cfg_wr <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (cfg_we && (widx == widx_t'(i))) begin
          cfg[i]    <= CD_in;
          cfg_wr[i] <= 1'b1;
        end else begin
          cfg[i]    <= cfg[i] & ~SC_MASK[i*DW +: DW];
          cfg_wr[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg_out
    assign cfg_out[g*DW +: DW] = cfg[g];
  end

  always_comb begin
    cmd_word                 = '0;
    cmd_word[DW-1]           = err;
    cmd_word[DW-2]           = busy;
    cmd_word[DW-3]           = done;
    cmd_word[RMON_AW-1:0]    = CPU_rd_addr;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++)
      if (widx == widx_t'(i)) rd_data = cfg[i];
    if (widx == A_STAT) rd_data = DW'(sticky);
    if (widx == A_CMD)  rd_data = cmd_word;
    if (widx == A_LO)   rd_data = (DW == 16) ? DW'(dout_q[15:0]) : DW'(dout_q);
    if (widx == A_HI)   rd_data = (DW == 16) ? DW'(dout_q[31:16]) : '0;
`ifdef REG_WR_LOCK_EN
    if (widx == A_LOCK) rd_data = DW'(locked);
`endif
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset)          CD_out <= '0;
    else if (acc & WRB) CD_out <= rd_data;
  end

  // A status read returns every set bit, so all of them clear; same-cycle sets survive.
  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset)
      sticky <= '0;
    else if (rd_stb && (widx == A_STAT))
      sticky <= stat_set;
    else
      sticky <= sticky | stat_set;
  end

  always_ff @(posedge Clk_reg or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      CPU_rd_apply <= 1'b0;
      CPU_rd_addr  <= '0;
      dout_q       <= '0;
      tcnt         <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cmd_wr) begin
            CPU_rd_addr  <= CD_in[RMON_AW-1:0];
            done         <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b1;
            CPU_rd_apply <= 1'b1;
            tcnt         <= '0;
            state        <= S_REQ;
          end else if (state == S_DONE && rd_stb && (widx == A_HI)) begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (CPU_rd_grant) begin
            dout_q       <= CPU_rd_dout;
            done         <= 1'b1;
            busy         <= 1'b0;
            CPU_rd_apply <= 1'b0;
            state        <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            dout_q       <= 32'hFFFF_FFFF;
            err          <= 1'b1;
            busy         <= 1'b0;
            CPU_rd_apply <= 1'b0;
            state        <= S_DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state        <= S_IDLE;
          CPU_rd_apply <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_reg_file.sv
// tb/tb_host_reg_file.sv - directed self-checking bench for host_reg_file.
module tb_host_reg_file;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NREG = 8;
  localparam int NSTAT = 8;
  localparam int RMON_AW = 6;
  localparam int TIMEOUT = 10;
  localparam logic [NREG*DW-1:0] RV = {16'h0, 16'h0, 16'h0101, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0009};
  localparam logic [NREG*DW-1:0] SC = 128'h1 << 80;

  localparam logic [7:0] CA_STAT = 8'h10;
  localparam logic [7:0] CA_CMD  = 8'h12;
  localparam logic [7:0] CA_LO   = 8'h14;
  localparam logic [7:0] CA_HI   = 8'h16;
  localparam logic [7:0] CA_LOCK = 8'h18;
  localparam logic [7:0] CA_UNM  = 8'h28;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               csb = 1'b1;
  logic               wrb = 1'b1;
  logic [AW-1:0]      ca = '0;
  logic [DW-1:0]      cd_in = '0;
  logic [DW-1:0]      cd_out;
  logic [NREG*DW-1:0] cfg_out;
  logic [NREG-1:0]    cfg_wr;
  logic [NSTAT-1:0]   stat_set = '0;
  logic [RMON_AW-1:0] rd_addr;
  logic               apply;
  logic               grant = 1'b0;
  logic [31:0]        dout = '0;

  int checks = 0;
  int failures = 0;

  host_reg_file #(
    .DW(DW), .AW(AW), .NREG(NREG), .RST_VAL(RV), .SC_MASK(SC),
    .NSTAT(NSTAT), .RMON_AW(RMON_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk_reg(clk), .Reset(rst), .CSB(csb), .WRB(wrb), .CA(ca), .CD_in(cd_in),
    .CD_out(cd_out), .cfg_out(cfg_out), .cfg_wr(cfg_wr), .stat_set(stat_set),
    .CPU_rd_addr(rd_addr), .CPU_rd_apply(apply), .CPU_rd_grant(grant), .CPU_rd_dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    csb = 1'b0; wrb = 1'b0; ca = a; cd_in = d;
    tick();
    csb = 1'b1; wrb = 1'b1;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    csb = 1'b0; wrb = 1'b1; ca = a;
    tick();
    d = cd_out;
    csb = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (cfg_out[15:0] !== 16'h0009) begin failures++; $display("FAIL reset_cfg0 got=%h exp=0009", cfg_out[15:0]); end
    checks++; if (cfg_out[95:80] !== 16'h0100) begin failures++; $display("FAIL reset_cfg5_sc got=%h exp=0100", cfg_out[95:80]); end
    checks++; if (cd_out !== 16'h0000) begin failures++; $display("FAIL reset_cd_out got=%h exp=0000", cd_out); end
    checks++; if (apply !== 1'b0) begin failures++; $display("FAIL reset_apply got=%b exp=0", apply); end
    checks++; if (cfg_wr !== 8'h00 || rd_addr !== 6'h00) begin failures++; $display("FAIL reset_wr_addr got=%h/%h exp=00/00", cfg_wr, rd_addr); end
    rst = 1'b0;
    tick();
  endtask

`ifdef REG_WR_LOCK_EN
  task automatic test_lock();
    logic [15:0] v;
    bus_read(CA_LOCK, v);
    checks++; if (v !== 16'h0001) begin failures++; $display("FAIL lock_reset got=%h exp=0001", v); end
    csb = 1'b0; wrb = 1'b0; ca = 8'h04; cd_in = 16'h5555;
    tick();
    checks++; if (cfg_wr !== 8'h00) begin failures++; $display("FAIL lock_cfg_wr got=%h exp=00", cfg_wr); end
    csb = 1'b1; wrb = 1'b1;
    tick();
    checks++; if (cfg_out[47:32] !== 16'h0000) begin failures++; $display("FAIL lock_cfg2 got=%h exp=0000", cfg_out[47:32]); end
    bus_write(CA_LOCK, 16'hA5C3);
    bus_read(CA_LOCK, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL lock_unlocked got=%h exp=0000", v); end
  endtask
`endif

  task automatic test_cfg_write();
    int n;
    logic [15:0] v;
    n = 0;
    csb = 1'b0; wrb = 1'b0; ca = 8'h06; cd_in = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (cfg_wr[3]) n++;
      if (k == 0) cd_in = 16'hFFFF;
    end
    csb = 1'b1; wrb = 1'b1;
    tick();
    if (cfg_wr[3]) n++;
    checks++; if (n !== 1) begin failures++; $display("FAIL cfg_wr_pulse got=%0d exp=1", n); end
    checks++; if (cfg_out[63:48] !== 16'h1234) begin failures++; $display("FAIL cfg3_value got=%h exp=1234", cfg_out[63:48]); end
    bus_read(8'h06, v);
    checks++; if (v !== 16'h1234) begin failures++; $display("FAIL cfg3_readback got=%h exp=1234", v); end
    bus_read(8'h00, v);
    checks++; if (v !== 16'h0009) begin failures++; $display("FAIL cfg0_readback got=%h exp=0009", v); end
  endtask

  task automatic test_self_clear();
    logic [15:0] v;
    csb = 1'b0; wrb = 1'b0; ca = 8'h0A; cd_in = 16'h0001;
    tick();
    checks++; if (cfg_out[95:80] !== 16'h0001 || cfg_wr[5] !== 1'b1) begin failures++; $display("FAIL sc_set got=%h/%b exp=0001/1", cfg_out[95:80], cfg_wr[5]); end
    csb = 1'b1; wrb = 1'b1;
    tick();
    checks++; if (cfg_out[95:80] !== 16'h0000) begin failures++; $display("FAIL sc_clear got=%h exp=0000", cfg_out[95:80]); end
    bus_read(8'h0A, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL sc_readback got=%h exp=0000", v); end
  endtask

  task automatic test_sticky();
    logic [15:0] v;
    stat_set = 8'h04; tick(); stat_set = 8'h00;
    bus_read(CA_STAT, v);
    checks++; if (v !== 16'h0004) begin failures++; $display("FAIL sticky_first got=%h exp=0004", v); end
    bus_read(CA_STAT, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL sticky_cleared got=%h exp=0000", v); end
    stat_set = 8'h04; tick(); stat_set = 8'h00;
    csb = 1'b0; wrb = 1'b1; ca = CA_STAT; stat_set = 8'h04;
    tick();
    checks++; if (cd_out !== 16'h0004) begin failures++; $display("FAIL sticky_race_read got=%h exp=0004", cd_out); end
    csb = 1'b1; stat_set = 8'h00;
    tick();
    bus_read(CA_STAT, v);
    checks++; if (v !== 16'h0004) begin failures++; $display("FAIL sticky_race_kept got=%h exp=0004", v); end
    bus_read(CA_STAT, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL sticky_race_clear got=%h exp=0000", v); end
  endtask

  task automatic test_rmon_grant();
    int n;
    logic [15:0] v;
    csb = 1'b0; wrb = 1'b0; ca = CA_CMD; cd_in = 16'h0015;
    tick();
    csb = 1'b1; wrb = 1'b1;
    checks++; if (rd_addr !== 6'h15) begin failures++; $display("FAIL rmon_addr got=%h exp=15", rd_addr); end
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (apply) n++;
      if (k == 2) begin grant = 1'b1; dout = 32'hDEAD_BEEF; end
      tick();
      grant = 1'b0;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL rmon_apply_cycles got=%0d exp=3", n); end
    bus_read(CA_CMD, v);
    checks++; if (v !== 16'h2015) begin failures++; $display("FAIL rmon_cmd_done got=%h exp=2015", v); end
    bus_read(CA_LO, v);
    checks++; if (v !== 16'hBEEF) begin failures++; $display("FAIL rmon_lo got=%h exp=BEEF", v); end
    bus_read(CA_HI, v);
    checks++; if (v !== 16'hDEAD) begin failures++; $display("FAIL rmon_hi got=%h exp=DEAD", v); end
    bus_read(CA_CMD, v);
    checks++; if (v !== 16'h2015) begin failures++; $display("FAIL rmon_idle_done got=%h exp=2015", v); end
    grant = 1'b1; dout = 32'h1234_5678; tick(); grant = 1'b0;
    bus_read(CA_LO, v);
    checks++; if (v !== 16'hBEEF) begin failures++; $display("FAIL rmon_stray_grant got=%h exp=BEEF", v); end
  endtask

  task automatic test_rmon_timeout();
    int n;
    logic [15:0] v;
    logic [15:0] busy_rd;
    busy_rd = '0;
    csb = 1'b0; wrb = 1'b0; ca = CA_CMD; cd_in = 16'h0007;
    tick();
    csb = 1'b1; wrb = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      if (apply) n++;
      case (k)
        2: begin csb = 1'b0; wrb = 1'b0; ca = CA_CMD; cd_in = 16'h0003; end
        3: begin csb = 1'b1; wrb = 1'b1; end
        5: begin csb = 1'b0; wrb = 1'b1; ca = CA_CMD; end
        6: begin busy_rd = cd_out; csb = 1'b1; end
        default: ;
      endcase
      tick();
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL timeout_apply_cycles got=%0d exp=10", n); end
    checks++; if (busy_rd !== 16'h4007) begin failures++; $display("FAIL timeout_busy_read got=%h exp=4007", busy_rd); end
    checks++; if (rd_addr !== 6'h07) begin failures++; $display("FAIL req_write_ignored got=%h exp=07", rd_addr); end
    bus_read(CA_CMD, v);
    checks++; if (v !== 16'h8007) begin failures++; $display("FAIL timeout_err got=%h exp=8007", v); end
    bus_read(CA_LO, v);
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL timeout_lo got=%h exp=FFFF", v); end
    bus_read(CA_HI, v);
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL timeout_hi got=%h exp=FFFF", v); end
  endtask

  task automatic test_grant_at_timeout();
    int n;
    logic [15:0] v;
    bus_write(CA_CMD, 16'h0009);
    n = 1;
    for (int k = 1; k < 13; k++) begin
      if (apply) n++;
      if (k == 9) begin grant = 1'b1; dout = 32'h0000_1111; end
      tick();
      grant = 1'b0;
    end
    checks++; if (n !== 10) begin failures++; $display("FAIL tie_apply_cycles got=%0d exp=10", n); end
    bus_read(CA_CMD, v);
    checks++; if (v !== 16'h2009) begin failures++; $display("FAIL tie_grant_wins got=%h exp=2009", v); end
    bus_read(CA_LO, v);
    checks++; if (v !== 16'h1111) begin failures++; $display("FAIL tie_lo got=%h exp=1111", v); end
  endtask

  task automatic test_unmapped();
    logic [15:0] v;
    logic [NREG*DW-1:0] snap;
    snap = cfg_out;
    bus_write(CA_UNM, 16'hBEEF);
    bus_read(CA_UNM, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h exp=0000", v); end
    checks++; if (cfg_out !== snap) begin failures++; $display("FAIL unmapped_write got=%h exp=%h", cfg_out, snap); end
`ifndef REG_WR_LOCK_EN
    bus_read(CA_LOCK, v);
    checks++; if (v !== 16'h0000) begin failures++; $display("FAIL lock_slot_unmapped got=%h exp=0000", v); end
`endif
  endtask

  task automatic test_reset_mid_req();
    bus_write(CA_CMD, 16'h002A);
    tick();
    checks++; if (apply !== 1'b1) begin failures++; $display("FAIL midreq_apply got=%b exp=1", apply); end
    #2 rst = 1'b1;
    #1;
    checks++; if (apply !== 1'b0) begin failures++; $display("FAIL midreq_async_drop got=%b exp=0", apply); end
    checks++; if (cfg_out[63:48] !== 16'h0000 || rd_addr !== 6'h00) begin failures++; $display("FAIL midreq_state got=%h/%h exp=0000/00", cfg_out[63:48], rd_addr); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
`ifdef REG_WR_LOCK_EN
    test_lock();
`endif
    test_cfg_write();
    test_self_clear();
    test_sticky();
    test_rmon_grant();
    test_rmon_timeout();
    test_grant_at_timeout();
    test_unmapped();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
